// File: rtl/syntzulu_spike_pkg.sv
// Shared spike-link helpers for the p2s serializer and the s2p deserializer.
// Defines the wire bit order and the counter-width helper.
package syntzulu_spike_pkg;

  // Groups travel most-significant spike first on the serial wire.
  localparam bit MSB_FIRST = 1'b1;

  function automatic int clogb2(input int value);
    int v;
    int r;
    r = 0;
    v = value;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/p2s.sv
// Parallel-to-serial spike serializer with a one-entry hold buffer.
// Optional macro P2S_ZERO_SKIP_EN drops all-zero groups and pulses skip instead.
module p2s
  import syntzulu_spike_pkg::*;
#(
  parameter int P = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [P-1:0] spike_p,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         stall,
  output logic         spike_s,
  output logic         en_out,
  output logic         last,
  output logic         active_group,
  output logic         skip
);

  localparam int            CW       = clogb2(P - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);

  logic [P-1:0]  sr_q, sr_d, hold_q, hold_d;
  logic          sr_full_q, sr_full_d, sr_act_q, sr_act_d;
  logic          hold_full_q, hold_full_d, hold_act_q, hold_act_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          spike_s_q, spike_s_d, en_out_q, en_out_d;
  logic          last_q, last_d, active_group_q, active_group_d;
  logic          skip_q, skip_d;

  logic hs, zero_drop, take, emit, group_end;

  // A zero group is still handshaked normally; it is just never stored.
`ifdef P2S_ZERO_SKIP_EN
  assign zero_drop = ~|spike_p;
`else
  assign zero_drop = 1'b0;
`endif

  assign hs        = in_valid & ~hold_full_q;
  assign take      = hs & ~zero_drop;
  assign emit      = sr_full_q & ~stall;
  assign group_end = emit & (cnt_q == CNT_LAST);

  always_comb begin
    sr_d           = sr_q;
    sr_full_d      = sr_full_q;
    sr_act_d       = sr_act_q;
    hold_d         = hold_q;
    hold_full_d    = hold_full_q;
    hold_act_d     = hold_act_q;
    cnt_d          = cnt_q;
    spike_s_d      = 1'b0;
    en_out_d       = 1'b0;
    last_d         = 1'b0;
    active_group_d = 1'b0;
    skip_d         = hs & zero_drop;

    if (emit) begin
      spike_s_d      = MSB_FIRST ? sr_q[P-1] : sr_q[0];
      en_out_d       = 1'b1;
      last_d         = group_end;
      active_group_d = sr_act_q;
      sr_d           = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
      cnt_d          = cnt_q + 1'b1;
    end

    // Hold always wins the reload; in_ready is low whenever hold is full.
    if (group_end) begin
      cnt_d = '0;
      if (hold_full_q) begin
        sr_d        = hold_q;
        sr_act_d    = hold_act_q;
        hold_full_d = 1'b0;
      end else if (take) begin
        sr_d     = spike_p;
        sr_act_d = |spike_p;
      end else begin
        sr_full_d = 1'b0;
      end
    end else if (take) begin
      if (!sr_full_q) begin
        sr_d      = spike_p;
        sr_act_d  = |spike_p;
        sr_full_d = 1'b1;
      end else begin
        hold_d      = spike_p;
        hold_act_d  = |spike_p;
        hold_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q           <= '0;
      sr_full_q      <= 1'b0;
      sr_act_q       <= 1'b0;
      hold_q         <= '0;
      hold_full_q    <= 1'b0;
      hold_act_q     <= 1'b0;
      cnt_q          <= '0;
      spike_s_q      <= 1'b0;
      en_out_q       <= 1'b0;
      last_q         <= 1'b0;
      active_group_q <= 1'b0;
      skip_q         <= 1'b0;
    end else begin
      sr_q           <= sr_d;
      sr_full_q      <= sr_full_d;
      sr_act_q       <= sr_act_d;
      hold_q         <= hold_d;
      hold_full_q    <= hold_full_d;
      hold_act_q     <= hold_act_d;
      cnt_q          <= cnt_d;
      spike_s_q      <= spike_s_d;
      en_out_q       <= en_out_d;
      last_q         <= last_d;
      active_group_q <= active_group_d;
      skip_q         <= skip_d;
    end
  end

  assign in_ready     = ~hold_full_q;
  assign spike_s      = spike_s_q;
  assign en_out       = en_out_q;
  assign last         = last_q;
  assign active_group = active_group_q;
  assign skip         = skip_q;

endmodule

// File: tb/tb_p2s.sv
// Self-checking bench for p2s (P=4): directed steps plus randomized traffic
// scored against a queue of expected serial bits.
module tb_p2s;

  localparam int P = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [P-1:0] spike_p = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         stall = 1'b0;
  logic         spike_s, en_out, last, active_group, skip;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic b;
    logic l;
    logic a;
  } exp_bit_t;

  exp_bit_t exp_q[$];
  logic     started = 1'b0;
  logic     prev_stall = 1'b0;
  logic     exp_skip = 1'b0;

  int cyc = 0, en_total = 0, en_first = -1, en_last = -1, skip_total = 0;

  p2s #(.P(P)) dut (
    .clk(clk), .rst(rst), .spike_p(spike_p), .in_valid(in_valid),
    .in_ready(in_ready), .stall(stall), .spike_s(spike_s), .en_out(en_out),
    .last(last), .active_group(active_group), .skip(skip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: each accepted group becomes P wire bits, MSB first.
  always @(posedge clk) begin
    prev_stall <= stall;
    if (rst) begin
      exp_q.delete();
      exp_skip <= 1'b0;
    end else begin
      exp_skip <= 1'b0;
      if (in_valid && in_ready) begin
`ifdef P2S_ZERO_SKIP_EN
        if (spike_p == '0) exp_skip <= 1'b1;
        else
`endif
        for (int i = P - 1; i >= 0; i--)
          exp_q.push_back('{b: spike_p[i], l: (i == 0), a: (spike_p != '0)});
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("skip", skip, exp_skip);
      if (prev_stall) chk("stall_en", en_out, 1'b0);
      if (en_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_en", 1'b1, 1'b0);
        end else begin
          exp_bit_t e;
          e = exp_q.pop_front();
          chk("spike_s", spike_s, e.b);
          chk("last", last, e.l);
          chk("active_group", active_group, e.a);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (en_out) begin
      en_total++;
      if (en_first < 0) en_first = cyc;
      en_last = cyc;
    end
    if (skip) skip_total++;
  endtask

  task automatic clr_stats();
    en_total = 0;
    en_first = -1;
    en_last = -1;
    skip_total = 0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    in_valid = 1'b0;
    stall = 1'b0;
    while ((exp_q.size() != 0 || en_out) && n < 200) begin
      tick();
      n++;
    end
    tick();
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    logic [P-1:0] grp [3];
    int  idx, n, sent;
    logic saw_not_ready, acc;

    grp[0] = 4'b1010;
    grp[1] = 4'b0111;
    grp[2] = 4'b1001;

    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    started = 1'b1;
    chk("rst_en_out", en_out, 1'b0);
    chk("rst_spike_s", spike_s, 1'b0);
    chk("rst_last", last, 1'b0);
    chk("rst_active", active_group, 1'b0);
    chk("rst_skip", skip, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Single group: first en_out appears after the second edge.
    clr_stats();
    spike_p = 4'b1010;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_en_k", en_out, 1'b0);
    tick();
    chk("lat_en_k1", en_out, 1'b1);
    chk("lat_first_bit", spike_s, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    chk("single_en_count", en_total, 4);
    chk("single_en_span", en_last - en_first + 1, 4);
    drain("single_drain");

    // Three back-to-back groups with valid held high.
    clr_stats();
    idx = 0;
    n = 0;
    saw_not_ready = 1'b0;
    while (idx < 3 && n < 50) begin
      spike_p = grp[idx];
      in_valid = 1'b1;
      acc = in_ready;
      if (!in_ready) saw_not_ready = 1'b1;
      tick();
      if (acc) idx++;
      n++;
    end
    in_valid = 1'b0;
    chk("b2b_accepted", idx, 3);
    chk("b2b_not_ready_seen", saw_not_ready, 1'b1);
    for (int i = 0; i < 16; i++) tick();
    chk("b2b_en_count", en_total, 12);
    chk("b2b_en_span", en_last - en_first + 1, 12);
    drain("b2b_drain");

    // Stall after the second bit of 1100; hold fills during the stall.
    clr_stats();
    spike_p = 4'b1100;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("stall_pre_bit2", spike_s, 1'b1);
    stall = 1'b1;
    spike_p = 4'b0110;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("stall_en0", en_out, 1'b0);
    chk("stall_hold_full", in_ready, 1'b0);
    tick();
    chk("stall_en1", en_out, 1'b0);
    tick();
    chk("stall_en2", en_out, 1'b0);
    stall = 1'b0;
    tick();
    chk("resume_en", en_out, 1'b1);
    chk("resume_bit", spike_s, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    chk("stall_en_total", en_total, 8);
    drain("stall_drain");

    // Reset after two bits with hold full.
    spike_p = 4'b1011;
    in_valid = 1'b1;
    tick();
    spike_p = 4'b0111;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_rst_hold_full", in_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_en", en_out, 1'b0);
    chk("post_rst_spike", spike_s, 1'b0);
    chk("post_rst_last", last, 1'b0);
    chk("post_rst_ready", in_ready, 1'b1);
    clr_stats();
    spike_p = 4'b0001;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("post_rst_en_count", en_total, 4);
    drain("post_rst_drain");

    // Zero group followed by a normal group.
    clr_stats();
    spike_p = 4'b0000;
    in_valid = 1'b1;
    tick();
    spike_p = 4'b0110;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
`ifdef P2S_ZERO_SKIP_EN
    chk("zero_en_count", en_total, 4);
    chk("zero_skip_count", skip_total, 1);
`else
    chk("zero_en_count", en_total, 8);
    chk("zero_skip_count", skip_total, 0);
`endif
    drain("zero_drain");

    // Randomized traffic with random stall.
    sent = 0;
    n = 0;
    while (sent < 100 && n < 3000) begin
      if (!in_valid && $urandom_range(0, 1) == 1) begin
        spike_p = P'($urandom);
        in_valid = 1'b1;
      end
      stall = ($urandom_range(0, 3) == 0);
      acc = in_valid & in_ready;
      tick();
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
      n++;
    end
    chk("rand_sent", sent, 100);
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
